slink_app_tx_packetizer: RTL and testbench

Synthesizable packetizer for the S-Link TX application interface, the transmit-side counterpart of the RX application monitor path. It accepts a packet as a serial byte stream (data ID, word count low, word count high, then payload), packs the bytes into APP_DATA_WIDTH beats, and presents them to the link layer with SOP/valid and an advance handshake. It sits between a byte-oriented packet source (test sequencer or application FIFO) and the S-Link TX application ports.

---
 rtl/slink_app_tx_packetizer.sv | 145 ++++++++++++++
 tb/tb_slink_app_tx_packetizer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_app_tx_packetizer.sv
// S-Link TX application packetizer: packs a serial header+payload byte stream into
// APP_DATA_WIDTH beats presented to the link layer with SOP/valid and advance handshake.
module slink_app_tx_packetizer #(
   parameter int unsigned APP_DATA_WIDTH = 32
) (
   input  logic                      link_clk,
   input  logic                      link_reset,
   input  logic                      in_valid,
   input  logic [7:0]                in_byte,
   output logic                      in_ready,
   output logic                      tx_sop,
   output logic                      tx_valid,
   output logic [7:0]                tx_data_id,
   output logic [15:0]               tx_word_count,
   output logic [APP_DATA_WIDTH-1:0] tx_app_data,
   input  logic                      tx_advance,
   output logic                      pkt_done
);

   localparam int unsigned BYTES  = APP_DATA_WIDTH / 8;
   localparam int unsigned LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {StHdr, StFill, StSend} state_e;

   state_e                    state_q, state_d;
   logic [1:0]                hdr_cnt_q, hdr_cnt_d;
   logic [7:0]                id_q, id_d;
   logic [15:0]               wc_q, wc_d;
   logic [APP_DATA_WIDTH-1:0] data_q, data_d;
   logic [16:0]               rem_q, rem_d;
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic                      sop_pend_q, sop_pend_d;
   logic                      sop_q, sop_d;
   logic                      done_q, done_d;
   logic                      accept;

   // in_ready is held low while reset is asserted, so a byte can never be lost to reset.
   assign in_ready      = !link_reset && (state_q != StSend);
   assign accept        = in_valid && in_ready;
   assign tx_valid      = (state_q == StSend);
   assign tx_sop        = sop_q;
   assign tx_data_id    = id_q;
   assign tx_word_count = wc_q;
   assign tx_app_data   = data_q;
   assign pkt_done      = done_q;

   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      id_d       = id_q;
      wc_d       = wc_q;
      data_d     = data_q;
      rem_d      = rem_q;
      lane_d     = lane_q;
      sop_pend_d = sop_pend_q;
      sop_d      = sop_q;
      done_d     = 1'b0;
      unique case (state_q)
         StHdr: begin
            if (accept) begin
               unique case (hdr_cnt_q)
                  2'd0: begin
                     id_d      = in_byte;
                     hdr_cnt_d = 2'd1;
                  end
                  2'd1: begin
                     wc_d[7:0] = in_byte;
                     hdr_cnt_d = 2'd2;
                  end
                  default: begin
                     wc_d[15:8] = in_byte;
                     hdr_cnt_d  = 2'd0;
                     data_d     = '0;
                     lane_d     = '0;
                     // Short packets and empty long packets go out as a single header-only beat.
                     if (id_q <= 8'h1F || {in_byte, wc_q[7:0]} == 16'd0) begin
                        rem_d   = '0;
                        sop_d   = 1'b1;
                        state_d = StSend;
                     end else begin
                        rem_d      = {1'b0, in_byte, wc_q[7:0]};
                        sop_pend_d = 1'b1;
                        state_d    = StFill;
                     end
                  end
               endcase
            end
         end
         StFill: begin
            if (accept) begin
               data_d[{lane_q, 3'b000} +: 8] = in_byte;
               rem_d  = rem_q - 17'd1;
               lane_d = lane_q + 1'b1;
               if (lane_q == LANE_W'(BYTES - 1) || rem_q == 17'd1) begin
                  lane_d     = '0;
                  sop_d      = sop_pend_q;
                  sop_pend_d = 1'b0;
                  state_d    = StSend;
               end
            end
         end
         StSend: begin
            if (tx_advance) begin
               sop_d = 1'b0;
               if (rem_q != 17'd0) begin
                  data_d  = '0;
                  lane_d  = '0;
                  state_d = StFill;
               end else begin
                  done_d  = 1'b1;
                  state_d = StHdr;
               end
            end
         end
         default: state_d = StHdr;
      endcase
   end

   always_ff @(posedge link_clk or posedge link_reset) begin
      if (link_reset) begin
         state_q    <= StHdr;
         hdr_cnt_q  <= '0;
         id_q       <= '0;
         wc_q       <= '0;
         data_q     <= '0;
         rem_q      <= '0;
         lane_q     <= '0;
         sop_pend_q <= 1'b0;
         sop_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         id_q       <= id_d;
         wc_q       <= wc_d;
         data_q     <= data_d;
         rem_q      <= rem_d;
         lane_q     <= lane_d;
         sop_pend_q <= sop_pend_d;
         sop_q      <= sop_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_slink_app_tx_packetizer.sv
// Randomized self-checking bench for slink_app_tx_packetizer; beats are scored against a
// packet-level model that splits each byte stream into expected beats.
module tb_slink_app_tx_packetizer;

   localparam int W = 32;
   localparam int BYTES = W / 8;

   typedef struct {
      logic [7:0]   id;
      logic [15:0]  wc;
      logic         sop;
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   logic         link_clk = 1'b0;
   logic         link_reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [7:0]   in_byte = 8'h00;
   logic         in_ready;
   logic         tx_sop;
   logic         tx_valid;
   logic [7:0]   tx_data_id;
   logic [15:0]  tx_word_count;
   logic [W-1:0] tx_app_data;
   logic         tx_advance = 1'b0;
   logic         pkt_done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0;
   int adv_delay = 0;   // <0 selects a random stall per beat
   beat_t exp_q[$];
   logic [7:0] pl[$];

   // monitor state
   beat_t cur;
   beat_t snap;
   logic  in_beat = 1'b0;
   logic  exp_done = 1'b0;
   int    wait_cnt = 0;
   int    target = 0;

   slink_app_tx_packetizer #(.APP_DATA_WIDTH(W)) dut (
      .link_clk      (link_clk),
      .link_reset    (link_reset),
      .in_valid      (in_valid),
      .in_byte       (in_byte),
      .in_ready      (in_ready),
      .tx_sop        (tx_sop),
      .tx_valid      (tx_valid),
      .tx_data_id    (tx_data_id),
      .tx_word_count (tx_word_count),
      .tx_app_data   (tx_app_data),
      .tx_advance    (tx_advance),
      .pkt_done      (pkt_done)
   );

   always #5 link_clk = ~link_clk;
   always @(posedge link_clk) cyc <= cyc + 1;

   // Beat monitor and link-side sink: scores every beat, checks hold-stability and pkt_done.
   always @(negedge link_clk) begin
      if (link_reset) begin
         in_beat = 1'b0;
         exp_done = 1'b0;
         tx_advance = 1'b0;
      end else begin
         vectors++;
         if (pkt_done !== exp_done) begin
            miscompares++;
            $display("FAIL pkt_done: got %b want %b at cyc %0d", pkt_done, exp_done, cyc);
         end
         exp_done = 1'b0;
         if (pkt_done === 1'b1) done_cnt++;
         if (tx_valid === 1'b1) begin
            vectors++;
            if (in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL ready_while_valid: got %b want 0", in_ready);
            end
            if (!in_beat) begin
               in_beat = 1'b1;
               wait_cnt = 0;
               target = (adv_delay < 0) ? int'($urandom_range(0, 3)) : adv_delay;
               snap.id = tx_data_id; snap.wc = tx_word_count;
               snap.sop = tx_sop; snap.data = tx_app_data;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  cur.last = 1'b0;
                  $display("FAIL unexpected_beat: got id %h data %h want none", tx_data_id,
                           tx_app_data);
               end else begin
                  cur = exp_q.pop_front();
                  if ({tx_sop, tx_data_id, tx_word_count, tx_app_data} !==
                      {cur.sop, cur.id, cur.wc, cur.data}) begin
                     miscompares++;
                     $display("FAIL beat: got sop %b id %h wc %h data %h want sop %b id %h wc %h data %h",
                              tx_sop, tx_data_id, tx_word_count, tx_app_data,
                              cur.sop, cur.id, cur.wc, cur.data);
                  end
               end
            end else begin
               vectors++;
               if ({tx_sop, tx_data_id, tx_word_count, tx_app_data} !==
                   {snap.sop, snap.id, snap.wc, snap.data}) begin
                  miscompares++;
                  $display("FAIL beat_stable: got id %h wc %h data %h want id %h wc %h data %h",
                           tx_data_id, tx_word_count, tx_app_data, snap.id, snap.wc, snap.data);
               end
            end
            if (wait_cnt >= target) begin
               tx_advance = 1'b1;
               in_beat = 1'b0;
               exp_done = cur.last;
            end else begin
               tx_advance = 1'b0;
               wait_cnt++;
            end
         end else begin
            tx_advance = 1'($urandom_range(0, 1));  // must be ignored while not valid
         end
      end
   end

   // Reference model: split a packet into the beats the link should see.
   task automatic model_pkt(input logic [7:0] id, input logic [15:0] wc);
      beat_t b;
      if (id <= 8'h1F || wc == 16'd0) begin
         b.id = id; b.wc = wc; b.sop = 1'b1; b.data = '0; b.last = 1'b1;
         exp_q.push_back(b);
      end else begin
         for (int i = 0; i < int'(wc); i += BYTES) begin
            b.id = id; b.wc = wc; b.sop = (i == 0); b.data = '0;
            b.last = (i + BYTES >= int'(wc));
            for (int j = 0; j < BYTES; j++)
               if (i + j < int'(wc)) b.data[j*8 +: 8] = pl[i + j];
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      logic acc;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge link_clk); #1; end
      in_valid = 1'b1;
      in_byte = b;
      n = 0;
      acc = 1'b0;
      do begin
         @(negedge link_clk);
         acc = in_ready;
         @(posedge link_clk); #1;
         n++;
      end while (!acc && n < 1000);
      in_valid = 1'b0;
      if (!acc) begin
         miscompares++;
         $display("FAIL byte_accept_timeout: got no acceptance want accept of %h", b);
      end
   endtask

   task automatic send_pkt(input logic [7:0] id, input logic [15:0] wc, input int maxgap);
      model_pkt(id, wc);
      send_byte(id, $urandom_range(0, maxgap));
      send_byte(wc[7:0], $urandom_range(0, maxgap));
      send_byte(wc[15:8], $urandom_range(0, maxgap));
      if (id > 8'h1F && wc != 16'd0)
         for (int i = 0; i < int'(wc); i++) send_byte(pl[i], $urandom_range(0, maxgap));
   endtask

   task automatic fill_payload(input int n);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || in_beat) && n < 2000) begin
         @(negedge link_clk);
         n++;
      end
      repeat (2) @(negedge link_clk);
      @(posedge link_clk); #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
      end
   endtask

   task automatic wait_done(output int t);
      int n = 0;
      do begin @(negedge link_clk); n++; end while (pkt_done !== 1'b1 && n < 100);
      t = cyc;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge link_clk);
      vectors++;
      if ({in_ready, tx_valid, tx_sop, tx_data_id, tx_word_count, tx_app_data, pkt_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy %b v %b sop %b id %h wc %h data %h done %b want all 0",
                  in_ready, tx_valid, tx_sop, tx_data_id, tx_word_count, tx_app_data, pkt_done);
      end
      @(posedge link_clk); #1;
      link_reset = 1'b0;
      @(negedge link_clk);
      vectors++;
      if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: got rdy %b valid %b want 1 0", in_ready, tx_valid);
      end
      @(posedge link_clk); #1;
   endtask

   task automatic test_short();
      int t0, t1;
      adv_delay = 0;
      t0 = cyc;
      model_pkt(8'h05, 16'h1234);
      send_byte(8'h05, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      vectors++;
      if (tx_valid !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL short_latency: got valid %b rdy %b want 1 0", tx_valid, in_ready);
      end
      wait_done(t1);
      vectors++;
      if (t1 - t0 != 4 || tx_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL short_period: got %0d cycles valid %b rdy %b want 4 cycles valid 0 rdy 1",
                  t1 - t0, tx_valid, in_ready);
      end
      wait_idle();
   endtask

   task automatic test_long();
      int t0, t1;
      adv_delay = 0;
      pl.delete();
      for (int i = 0; i < 5; i++) pl.push_back(8'(8'hA0 + i));
      t0 = cyc;
      send_pkt(8'h2A, 16'd5, 0);
      wait_done(t1);
      vectors++;
      if (t1 - t0 != 3 + 5 + 2) begin
         miscompares++;
         $display("FAIL long_period: got %0d cycles want %0d", t1 - t0, 10);
      end
      wait_idle();
   endtask

   task automatic test_long_wc0();
      adv_delay = 0;
      send_pkt(8'h40, 16'h0000, 0);
      send_pkt(8'h1F, 16'hBEEF, 0);  // follows immediately: must be parsed as a header
      wait_idle();
   endtask

   task automatic test_backpressure();
      adv_delay = 10;
      fill_payload(8);
      send_pkt(8'h33, 16'd8, 0);
      wait_idle();
      adv_delay = 0;
   endtask

   task automatic test_reset_mid();
      adv_delay = 0;
      send_byte(8'h30, 0); send_byte(8'h06, 0); send_byte(8'h00, 0);
      send_byte(8'hC1, 0); send_byte(8'hC2, 0);
      #2 link_reset = 1'b1;
      #1;
      exp_q.delete();
      vectors++;
      if ({in_ready, tx_valid, tx_sop, tx_data_id, tx_word_count, tx_app_data, pkt_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: got rdy %b v %b id %h wc %h data %h want all 0",
                  in_ready, tx_valid, tx_data_id, tx_word_count, tx_app_data);
      end
      @(posedge link_clk); #1;
      link_reset = 1'b0;
      send_pkt(8'h01, 16'h00FF, 0);
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [15:0] wc;
      adv_delay = -1;
      d0 = done_cnt;
      send_pkt(8'($urandom_range(0, 31)), 16'($urandom), 3);
      wc = 16'($urandom_range(1, 13));
      fill_payload(int'(wc));
      send_pkt(8'($urandom_range(32, 255)), wc, 3);
      send_pkt(8'($urandom_range(0, 31)), 16'($urandom), 3);
      wait_idle();
      vectors++;
      if (done_cnt - d0 != 3) begin
         miscompares++;
         $display("FAIL b2b_pkt_done: got %0d pulses want 3", done_cnt - d0);
      end
   endtask

   task automatic test_random();
      logic [15:0] wc;
      adv_delay = -1;
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            send_pkt(8'($urandom_range(0, 31)), 16'($urandom), 2);
         end else begin
            wc = 16'($urandom_range(0, 17));
            fill_payload(int'(wc));
            send_pkt(8'($urandom_range(32, 255)), wc, 2);
         end
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_long_wc0();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
